digital_lock_seq: RTL and testbench

Parametrised successor to the 4-bit pushbutton lock. The user enters a code of CODE_LEN digits, each DIGIT_W bits wide, one digit per enter press. The lock adds a timed unlock window, an attempt counter with timed or permanent lockout, and in-field code reprogramming while unlocked. It sits behind the clock divider in the top level and drives the front-panel LEDs directly.

---
 rtl/lock_pkg.sv | 31 +++
 rtl/pb_edge_sync.sv | 31 +++
 rtl/digital_lock_seq.sv | 200 ++++++++++++++++++++
 tb/tb_digital_lock_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and width helpers for the digit-sequence lock.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_PROGRAM  = 3'd3,
    ST_LOCKOUT  = 3'd4
  } lock_state_t;

  function automatic int attempt_width(input int max_attempts);
    return $clog2(max_attempts + 1);
  endfunction

  function automatic int index_width(input int code_len);
    return (code_len > 1) ? $clog2(code_len) : 1;
  endfunction

  // One down-counter covers both windows, so size it for the longer one.
  function automatic int timer_width(input int unlock_cycles, input int lockout_cycles);
    int m;
    m = (unlock_cycles > lockout_cycles) ? unlock_cycles : lockout_cycles;
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

  localparam int AW     = attempt_width(3);
  localparam int IDX_W  = index_width(4);
  localparam int CODE_W = 4 * 4;

endpackage

// File: rtl/pb_edge_sync.sv
// Pushbutton conditioner: two-flop synchroniser followed by a registered
// rising-edge detector, giving one single-cycle pulse per press.
module pb_edge_sync (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/digital_lock_seq.sv
// Multi-digit code lock with timed unlock window, attempt-limited lockout
// and in-field code reprogramming while unlocked.
module digital_lock_seq
  import lock_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      admin_reset,
  input  logic                                      enter,
  input  logic                                      program_mode,
  input  logic [DIGIT_W-1:0]                        code_in,
  output logic                                      unlock_led,
  output logic                                      lockout_led,
  output logic [attempt_width(MAX_ATTEMPTS)-1:0]    attempt_led,
  output logic [index_width(CODE_LEN)-1:0]          digit_idx,
  output logic                                      error_pulse,
  output logic                                      prog_led
);

  localparam int ATT_W     = attempt_width(MAX_ATTEMPTS);
  localparam int DIG_IDX_W = index_width(CODE_LEN);
  localparam int BUF_W     = CODE_LEN * DIGIT_W;
  localparam int TMR_W     = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);

  lock_state_t          r_state;
  lock_state_t          w_state_next;
  logic [DIG_IDX_W-1:0] r_idx;
  logic [DIG_IDX_W-1:0] w_idx_next;
  logic [BUF_W-1:0]     r_buf;
  logic [BUF_W-1:0]     w_buf_next;
  logic [BUF_W-1:0]     w_buf_wr;
  logic [BUF_W-1:0]     r_code;
  logic [BUF_W-1:0]     w_code_next;
  logic [ATT_W-1:0]     r_att;
  logic [ATT_W-1:0]     w_att_next;
  logic [ATT_W-1:0]     w_att_inc;
  logic [TMR_W-1:0]     r_timer;
  logic [TMR_W-1:0]     w_timer_next;
  logic                 w_err_next;
  logic                 r_err;
  logic                 r_unlock_led;
  logic                 r_lockout_led;
  logic                 r_prog_led;
  logic                 w_press;
  logic                 w_last;

  pb_edge_sync u_enter_sync (
    .clk     (clk),
    .i_rst_n (reset),
    .i_btn   (enter),
    .o_pulse (w_press)
  );

  // Entry and program staging share one buffer; digit 0 lives in the MS slot.
  generate
    for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_slot
      assign w_buf_wr[(CODE_LEN-1-gi)*DIGIT_W +: DIGIT_W] =
        (r_idx == DIG_IDX_W'(gi)) ? code_in : r_buf[(CODE_LEN-1-gi)*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  assign w_last    = (r_idx == DIG_IDX_W'(CODE_LEN - 1));
  assign w_att_inc = (r_att == ATT_W'(MAX_ATTEMPTS)) ? r_att : r_att + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_buf_next   = r_buf;
    w_code_next  = r_code;
    w_att_next   = r_att;
    w_timer_next = r_timer;
    w_err_next   = 1'b0;

    unique case (r_state)
      ST_ENTRY: begin
        if (w_press) begin
          w_buf_next = w_buf_wr;
          if (w_last) begin
            w_idx_next   = '0;
            w_state_next = ST_CHECK;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end

      // Whole-code compare only, so a wrong early digit is never revealed.
      ST_CHECK: begin
        if (r_buf == r_code) begin
          w_state_next = ST_UNLOCKED;
          w_att_next   = '0;
          w_timer_next = TMR_W'(UNLOCK_CYCLES);
        end else begin
          w_err_next = 1'b1;
          w_att_next = w_att_inc;
          if (w_att_inc == ATT_W'(MAX_ATTEMPTS)) begin
            w_state_next = ST_LOCKOUT;
            w_timer_next = TMR_W'(LOCKOUT_CYCLES);
          end else begin
            w_state_next = ST_ENTRY;
          end
        end
      end

      // Expiry wins over a simultaneous program request.
      ST_UNLOCKED: begin
        if (r_timer <= TMR_W'(1)) begin
          w_state_next = ST_ENTRY;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer - 1'b1;
          if (w_press && program_mode) begin
            w_state_next = ST_PROGRAM;
            w_idx_next   = '0;
          end
        end
      end

      ST_PROGRAM: begin
        if (w_press) begin
          w_buf_next = w_buf_wr;
          if (w_last) begin
            w_code_next  = w_buf_wr;
            w_idx_next   = '0;
            w_state_next = ST_ENTRY;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end

      ST_LOCKOUT: begin
        if (LOCKOUT_CYCLES != 0) begin
          if (r_timer <= TMR_W'(1)) begin
            w_state_next = ST_ENTRY;
            w_att_next   = '0;
            w_timer_next = '0;
          end else begin
            w_timer_next = r_timer - 1'b1;
          end
        end
      end

      default: begin
        w_state_next = ST_ENTRY;
        w_idx_next   = '0;
      end
    endcase

    if (admin_reset) begin
      w_state_next = ST_ENTRY;
      w_idx_next   = '0;
      w_att_next   = '0;
      w_timer_next = '0;
      w_err_next   = 1'b0;
      w_code_next  = r_code;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_ENTRY;
      r_idx         <= '0;
      r_buf         <= '0;
      r_code        <= DEFAULT_CODE;
      r_att         <= '0;
      r_timer       <= '0;
      r_err         <= 1'b0;
      r_unlock_led  <= 1'b0;
      r_lockout_led <= 1'b0;
      r_prog_led    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_buf         <= w_buf_next;
      r_code        <= w_code_next;
      r_att         <= w_att_next;
      r_timer       <= w_timer_next;
      r_err         <= w_err_next;
      r_unlock_led  <= (w_state_next == ST_UNLOCKED);
      r_lockout_led <= (w_state_next == ST_LOCKOUT);
      r_prog_led    <= (w_state_next == ST_PROGRAM);
    end
  end

  assign unlock_led  = r_unlock_led;
  assign lockout_led = r_lockout_led;
  assign prog_led    = r_prog_led;
  assign attempt_led = r_att;
  assign digit_idx   = r_idx;
  assign error_pulse = r_err;

endmodule

// File: tb/tb_digital_lock_seq.sv
// Directed bench: one default lock and one with permanent lockout, driven in parallel.
module tb_digital_lock_seq;
  import lock_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic admin_reset = 1'b0;
  logic enter = 1'b0;
  logic program_mode = 1'b0;
  logic [3:0] code_in = 4'h0;

  logic a_unlock, a_lockout, a_err, a_prog;
  logic b_unlock, b_lockout, b_err, b_prog;
  logic [AW-1:0] a_att, b_att;
  logic [IDX_W-1:0] a_idx, b_idx;

  int n_vec = 0;
  int n_bad = 0;
  int err_a = 0;
  int unlock_run = 0, unlock_last = 0;
  int lock_run = 0, lock_last = 0;
  int e0;

  always #5 clk = ~clk;

  digital_lock_seq dut_a (
    .clk(clk), .reset(reset), .admin_reset(admin_reset), .enter(enter),
    .program_mode(program_mode), .code_in(code_in),
    .unlock_led(a_unlock), .lockout_led(a_lockout), .attempt_led(a_att),
    .digit_idx(a_idx), .error_pulse(a_err), .prog_led(a_prog)
  );

  digital_lock_seq #(.LOCKOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .admin_reset(admin_reset), .enter(enter),
    .program_mode(program_mode), .code_in(code_in),
    .unlock_led(b_unlock), .lockout_led(b_lockout), .attempt_led(b_att),
    .digit_idx(b_idx), .error_pulse(b_err), .prog_led(b_prog)
  );

  // Run-length monitors for the LED windows and a per-cycle error pulse counter.
  always @(negedge clk) begin
    if (a_err) err_a++;
    if (a_unlock) unlock_run++;
    else if (unlock_run != 0) begin unlock_last = unlock_run; unlock_run = 0; end
    if (a_lockout) lock_run++;
    else if (lock_run != 0) begin lock_last = lock_run; lock_run = 0; end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    @(posedge clk); #2;
    code_in = d;
    enter = 1'b1;
    repeat (4) @(posedge clk);
    #2 enter = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic enter_code(input logic [CODE_W-1:0] code);
    for (int i = 0; i < 4; i++) press(code[CODE_W-1-4*i -: 4]);
    $display("code %04h entered: unlock=%0b lockout=%0b attempts=%0d", code, a_unlock, a_lockout, a_att);
  endtask

  task automatic admin_pulse();
    @(posedge clk); #2 admin_reset = 1'b1;
    @(posedge clk); #2 admin_reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_vec("rst_unlock", 32'(a_unlock), 0);
    check_vec("rst_lockout", 32'(a_lockout), 0);
    check_vec("rst_attempt", 32'(a_att), 0);
    check_vec("rst_idx", 32'(a_idx), 0);
    check_vec("rst_prog", 32'(a_prog), 0);
    check_vec("rst_err", 32'(a_err), 0);
    check_vec("rst_b_outs", 32'({b_unlock, b_lockout, b_prog, b_err, b_idx, b_att}), 0);
    @(posedge clk); #2 reset = 1'b1;

    // Correct code, exact unlock window, relock.
    e0 = err_a;
    press(4'h1); check_vec("t1_idx1", 32'(a_idx), 1);
    press(4'h2); check_vec("t1_idx2", 32'(a_idx), 2);
    press(4'h3); check_vec("t1_idx3", 32'(a_idx), 3);
    press(4'h4); check_vec("t1_idx0", 32'(a_idx), 0);
    check_vec("t1_unlock", 32'(a_unlock), 1);
    check_vec("t1_attempt", 32'(a_att), 0);
    for (int i = 0; i < 600 && a_unlock; i++) @(negedge clk);
    #1;
    check_vec("t1_relock", 32'(a_unlock), 0);
    check_vec("t1_window", 32'(unlock_last), 500);
    check_vec("t1_no_err", 32'(err_a - e0), 0);

    // Three wrong codes: attempts climb, third one locks out.
    for (int k = 1; k <= 3; k++) begin
      e0 = err_a;
      enter_code(16'h1235);
      check_vec("t2_err_pulse", 32'(err_a - e0), 1);
      check_vec("t2_attempt", 32'(a_att), 32'(k));
      check_vec("t2_lockout", 32'(a_lockout), (k == 3) ? 1 : 0);
    end
    check_vec("t2_b_lockout", 32'(b_lockout), 1);
    e0 = err_a;
    enter_code(16'h1234);
    check_vec("t2_press_ignored", 32'(a_unlock), 0);
    for (int i = 0; i < 1200 && a_lockout; i++) @(negedge clk);
    #1;
    check_vec("t2_lock_end", 32'(a_lockout), 0);
    check_vec("t2_lock_window", 32'(lock_last), 1000);
    check_vec("t2_att_clear", 32'(a_att), 0);
    check_vec("t2_no_err", 32'(err_a - e0), 0);

    // Permanent lockout holds until admin_reset.
    repeat (5000) @(negedge clk);
    check_vec("t3_b_still_locked", 32'(b_lockout), 1);
    check_vec("t3_b_attempt", 32'(b_att), 3);
    admin_pulse();
    check_vec("t3_b_released", 32'(b_lockout), 0);
    check_vec("t3_b_att_clear", 32'(b_att), 0);

    // Reprogram to 9876 while unlocked.
    enter_code(16'h1234);
    check_vec("t4_unlock", 32'(a_unlock), 1);
    program_mode = 1'b1;
    press(4'h5);
    program_mode = 1'b0;
    check_vec("t4_prog", 32'(a_prog), 1);
    check_vec("t4_prog_unlock", 32'(a_unlock), 0);
    check_vec("t4_prog_idx", 32'(a_idx), 0);
    press(4'h9); press(4'h8); press(4'h7);
    check_vec("t4_prog_idx3", 32'(a_idx), 3);
    press(4'h6);
    check_vec("t4_prog_done", 32'(a_prog), 0);
    check_vec("t4_unlock_after_prog", 32'(a_unlock), 0);
    e0 = err_a;
    enter_code(16'h1234);
    check_vec("t4_old_err", 32'(err_a - e0), 1);
    check_vec("t4_old_locked", 32'(a_unlock), 0);
    enter_code(16'h9876);
    check_vec("t4_new_unlock", 32'(a_unlock), 1);
    check_vec("t4_new_att", 32'(a_att), 0);
    @(posedge clk); #3 reset = 1'b0;
    #1 check_vec("t4_async_unlock", 32'(a_unlock), 0);
    @(posedge clk); #2 reset = 1'b1;
    enter_code(16'h1234);
    check_vec("t4_default_back", 32'(a_unlock), 1);
    admin_pulse();
    check_vec("t4_admin_relock", 32'(a_unlock), 0);

    // Held button gives one press; admin_reset discards a partial entry.
    @(posedge clk); #2 code_in = 4'h1; enter = 1'b1;
    repeat (50) @(posedge clk);
    #2 enter = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_vec("t5_hold_idx", 32'(a_idx), 1);
    press(4'h2);
    check_vec("t5_idx2", 32'(a_idx), 2);
    admin_pulse();
    check_vec("t5_admin_idx", 32'(a_idx), 0);
    enter_code(16'h1234);
    check_vec("t5_unlock", 32'(a_unlock), 1);
    admin_pulse();

    // admin_reset in the same cycle as the press pulse drops the press.
    @(posedge clk); #2 code_in = 4'h7; enter = 1'b1;
    repeat (3) @(posedge clk);
    #2 admin_reset = 1'b1;
    @(posedge clk); #2 admin_reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 enter = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_vec("t6_press_dropped", 32'(a_idx), 0);
    enter_code(16'h1234);
    check_vec("t6_unlock", 32'(a_unlock), 1);
    @(posedge clk); #3 reset = 1'b0;
    #1 check_vec("t6_async_unlock", 32'(a_unlock), 0);
    check_vec("t6_async_b_unlock", 32'(b_unlock), 0);
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
